// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_OSR    = 16;
  localparam int UART_DATA_W = 8;

  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;
  localparam logic [3:0] SC_LAST    = 4'(UART_OSR - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// rtl/uart_rx_tick.sv - oversample tick divider with synchronous clear
`timescale 1ns/1ps
module uart_rx_tick #(
  parameter int TICK_DIV = 78
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver with one-entry output buffer
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICK_DIV = 78
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   parity_err
);

  logic rx_s1, rx_s2, rx_s3;
  logic start_edge;

  uart_rx_state_t state, state_nx;
  logic armed, armed_nx;
  logic [3:0] sc;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [1:0] samp;
  logic [UART_DATA_W-1:0] shreg, shreg_nx;
  logic tick, cnt_clear;
  logic decide, bit_end, maj;
  logic deliver, ferr_set, perr_set;

  // Flops reset high so an idle line does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign start_edge = rx_s3 & ~rx_s2;

  uart_rx_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc <= '0;
    end else if (cnt_clear) begin
      sc <= '0;
    end else if (tick) begin
      sc <= sc + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= '0;
    end else if (tick) begin
      if (sc == SAMPLE_LO)  samp[0] <= rx_s2;
      if (sc == SAMPLE_MID) samp[1] <= rx_s2;
    end
  end

  // The third vote is the live sample taken on the deciding tick.
  assign decide  = tick && (sc == SAMPLE_HI);
  assign bit_end = tick && (sc == SC_LAST);
  assign maj     = majority3(samp[0], samp[1], rx_s2);

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_nx;
  logic par_bad;
  assign par_bad = par_bit ^ (^shreg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_bit <= 1'b0;
    else        par_bit <= par_bit_nx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      armed   <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      armed   <= armed_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    armed_nx   = armed;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    cnt_clear  = 1'b0;
    deliver    = 1'b0;
    ferr_set   = 1'b0;
    perr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_nx = par_bit;
`endif
    case (state)
      IDLE: begin
        if (rx_s2) armed_nx = 1'b1;
        if (armed && start_edge) begin
          cnt_clear = 1'b1;
          armed_nx  = 1'b0;
          state_nx  = START;
        end
      end
      START: begin
        if (decide && maj) begin
          state_nx = IDLE;
        end else if (bit_end) begin
          bit_cnt_nx = '0;
          state_nx   = DATA;
        end
      end
      DATA: begin
        if (decide) shreg_nx = {maj, shreg[UART_DATA_W-1:1]};
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide)  par_bit_nx = maj;
        if (bit_end) state_nx = STOP;
      end
`endif
      STOP: begin
        // Leave at the decision point so a back-to-back start edge is caught.
        if (decide) begin
          state_nx = IDLE;
          if (!maj) begin
            ferr_set = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            perr_set = 1'b1;
`endif
          end else begin
            deliver = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (valid && ready) overrun <= 1'b0;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= perr_set;
  end
`else
  logic unused_perr;
  assign unused_perr = perr_set;
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_T = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b0;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         v_cnt, fe_cnt, pe_cnt;
  logic [7:0] got;
  bit         busy_seen;
  logic       valid_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && !valid_prev) begin
        v_cnt++;
        got = data;
      end
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (busy)       busy_seen = 1'b1;
    end
    valid_prev = valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    v_cnt = 0; fe_cnt = 0; pe_cnt = 0; busy_seen = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit spike,
                            input bit par_flip);
    rx = 1'b0;
    cyc(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (spike) begin
        cyc(36);
        rx = ~b[i];
        cyc(1);
        rx = b[i];
        cyc(BIT_T - 37);
      end else begin
        cyc(BIT_T);
      end
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    cyc(BIT_T);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_v;
    cyc(BIT_T);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop_v;
    bit         spike;
    bit         par_flip;
    int         exp_v;
    logic [7:0] exp_d;
    int         exp_fe;
    int         exp_pe;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{8'h48, 1'b1, 1'b0, 1'b0, 1, 8'h48, 0, 0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 1, 8'h00, 0, 0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 1, 8'hFF, 0, 0});
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 1'b0, 1, 8'hA5, 0, 0});
    vecs.push_back('{8'hF0, 1'b1, 1'b1, 1'b0, 1, 8'hF0, 0, 0});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b1, 0, 8'h00, 0, 1});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 1, 8'h07, 0, 0});
    vecs.push_back('{8'h07, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1, 0});
`endif

    clr_mon();
    cyc(5);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    rst_n = 1'b1;
    cyc(20);

    ready = 1'b1;
    foreach (vecs[k]) begin
      clr_mon();
      send_frame(vecs[k].b, vecs[k].stop_v, vecs[k].spike, vecs[k].par_flip);
      rx = 1'b1;
      cyc(40);
      chk($sformatf("vec%0d_valid_cnt", k), v_cnt, vecs[k].exp_v);
      if (vecs[k].exp_v > 0) chk($sformatf("vec%0d_data", k), got, vecs[k].exp_d);
      chk($sformatf("vec%0d_frame_err", k), fe_cnt, vecs[k].exp_fe);
      chk($sformatf("vec%0d_parity_err", k), pe_cnt, vecs[k].exp_pe);
      chk($sformatf("vec%0d_busy_end", k), busy, 1'b0);
    end

    // short low glitch on an idle line
    clr_mon();
    rx = 1'b0;
    cyc(20);
    rx = 1'b1;
    cyc(100);
    chk("glitch_busy_seen", busy_seen, 1'b1);
    chk("glitch_busy_end", busy, 1'b0);
    chk("glitch_valid_cnt", v_cnt, 0);
    chk("glitch_frame_err", fe_cnt, 0);

    // back-to-back frames into a stalled buffer
    ready = 1'b0;
    clr_mon();
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    cyc(40);
    chk("ovr_valid_cnt", v_cnt, 1);
    chk("ovr_data", data, 8'h55);
    chk("ovr_valid", valid, 1'b1);
    chk("ovr_overrun", overrun, 1'b1);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    chk("ovr_release_valid", valid, 1'b0);
    chk("ovr_release_overrun", overrun, 1'b0);

    // stop bit low, then line held low (break)
    ready = 1'b1;
    clr_mon();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    cyc(3 * 10 * BIT_T);
    chk("brk_frame_err", fe_cnt, 1);
    chk("brk_valid_cnt", v_cnt, 0);
    chk("brk_busy", busy, 1'b0);
    rx = 1'b1;
    cyc(100);
    clr_mon();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    cyc(40);
    chk("brk_resume_valid_cnt", v_cnt, 1);
    chk("brk_resume_data", got, 8'h5A);

    // reset during bit 4 of a frame
    ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    cyc(40);
    chk("rstmid_pre_valid", valid, 1'b1);
    rx = 1'b0;
    cyc(BIT_T);
    cyc(4 * BIT_T + 10);
    chk("rstmid_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_data", data, 8'h00);
    chk("rstmid_valid", valid, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_overrun", overrun, 1'b0);
    rx = 1'b1;
    cyc(5);
    rst_n = 1'b1;
    cyc(100);
    ready = 1'b1;
    clr_mon();
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    rx = 1'b1;
    cyc(40);
    chk("rstmid_after_valid_cnt", v_cnt, 1);
    chk("rstmid_after_data", got, 8'h81);
    chk("rstmid_after_frame_err", fe_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
